// File: rtl/te_branch_map.sv
// E-Trace branch map accumulator: packs conditional-branch outcomes from the retirement
// stream into a bit map that the packet emitter consumes and clears with flush_i.
package mure_pkg;
  parameter int unsigned ITYPE_LEN = 3;
endpackage

module te_branch_map #(
  parameter  int unsigned MAX_BRANCHES = 31,
  localparam int unsigned CNT_W        = $clog2(MAX_BRANCHES + 1)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           iretire_i,
  input  logic [mure_pkg::ITYPE_LEN-1:0] itype_i,
  input  logic                           flush_i,
  output logic [MAX_BRANCHES-1:0]        map_o,
  output logic [CNT_W-1:0]               branches_o,
  output logic                           full_o,
  output logic                           empty_o,
  output logic                           overflow_o
);

  localparam logic [mure_pkg::ITYPE_LEN-1:0] ITYPE_NT = 4;
  localparam logic [mure_pkg::ITYPE_LEN-1:0] ITYPE_T  = 5;

  logic [MAX_BRANCHES-1:0] map_q, map_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    ovf_q, ovf_d;
  logic                    branch_ev;
  logic                    nt;
  logic                    full;

  assign nt        = (itype_i == ITYPE_NT);
  assign branch_ev = iretire_i && (nt || (itype_i == ITYPE_T));
  assign full      = (cnt_q == CNT_W'(MAX_BRANCHES));

  always_comb begin
    map_d = map_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (flush_i) begin
      // a branch arriving with the flush opens the fresh map rather than being lost
      map_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
      if (branch_ev) begin
        map_d[0] = nt;
        cnt_d    = CNT_W'(1);
      end
    end else if (branch_ev) begin
      if (!full) begin
        map_d = map_q | (MAX_BRANCHES'(nt) << cnt_q);
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      map_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      map_q <= map_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign map_o      = map_q;
  assign branches_o = cnt_q;
  assign full_o     = full;
  assign empty_o    = (cnt_q == '0);
  assign overflow_o = ovf_q;

endmodule
